alu_rf_ctrl: RTL and testbench

ALU_RF_CTRL -- requirements
Module: alu_rf_ctrl

---
 rtl/alu_rf_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_rf_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rf_ctrl.sv
// ---------------------------------------------------------------------------
// alu_rf_ctrl
//
// Register file plus sequencing FSM that feeds an external combinational ALU.
// One operation runs IDLE -> READ -> EXEC -> WB -> DONE: operands are read
// from the register file into A/B, the ALU result and flags are captured,
// the result is written back, and done pulses for one cycle. While idle, a
// direct load writes ld_data into R[rw]. R0 is hard-wired to zero.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, op         request one operation with ALU opcode op (IDLE only)
//   ra, rb, rw        source A, source B, destination register addresses
//   ld, ld_data       direct register load R[rw] <= ld_data (IDLE only)
//   A, B, ALU_OP      registered operands / opcode to the external ALU
//   F, ZF, OF         ALU result and flags from the external ALU
//   result, flags     last captured ALU result and {ZF,OF}
//   busy, done        operation in progress, one-cycle completion pulse
//   rd_addr, rd_data  combinational debug read port
// ---------------------------------------------------------------------------
module alu_rf_ctrl #(
    parameter int N_REG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic [4:0]  rw,
    input  logic        ld,
    input  logic [31:0] ld_data,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALU_OP,
    input  logic [31:0] F,
    input  logic        ZF,
    input  logic        OF,
    output logic [31:0] result,
    output logic [1:0]  flags,
    output logic        busy,
    output logic        done,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  op_lat;
    logic [4:0]  ra_lat;
    logic [4:0]  rb_lat;
    logic [4:0]  rw_lat;

    logic [31:0] regs [N_REG];

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ok;

    // R0 and any address beyond the implemented registers read as zero.
    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        if (addr == 5'd0 || int'(addr) >= N_REG) begin
            return 32'd0;
        end
        return regs[addr];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, status outputs and the single register-file write port.
    // start wins over ld in IDLE; both are ignored in every other state.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        wr_en      = 1'b0;
        wr_addr    = rw;
        wr_data    = ld_data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end else if (ld) begin
                    wr_en = 1'b1;
                end
            end
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB: begin
                state_next = DONE;
                wr_en      = 1'b1;
                wr_addr    = rw_lat;
                wr_data    = result;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writes to R0 (or unimplemented registers) are discarded.
    assign wr_ok = wr_en && (wr_addr != 5'd0) && (int'(wr_addr) < N_REG);

    // Datapath: request latch, operand/result registers and register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_lat <= '0;
            ra_lat <= '0;
            rb_lat <= '0;
            rw_lat <= '0;
            A      <= '0;
            B      <= '0;
            ALU_OP <= '0;
            result <= '0;
            flags  <= '0;
            for (int i = 0; i < N_REG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == IDLE && start) begin
                op_lat <= op;
                ra_lat <= ra;
                rb_lat <= rb;
                rw_lat <= rw;
            end
            if (state == READ) begin
                A      <= rf_read(ra_lat);
                B      <= rf_read(rb_lat);
                ALU_OP <= op_lat;
            end
            if (state == EXEC) begin
                result <= F;
                flags  <= {ZF, OF};
            end
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = rf_read(rd_addr);

endmodule

// File: tb/tb_alu_rf_ctrl.sv
// Bench for alu_rf_ctrl. The bench plays the external ALU and keeps its own
// register model; expected results are pushed to a queue when an operation
// is started and popped when done is observed.
module tb_alu_rf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  ra, rb, rw;
    logic        ld;
    logic [31:0] ld_data;
    logic [31:0] A, B;
    logic [2:0]  ALU_OP;
    logic [31:0] F;
    logic        ZF, OF;
    logic [31:0] result;
    logic [1:0]  flags;
    logic        busy, done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  flg;
        logic [4:0]  rw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mreg [32];

    alu_rf_ctrl #(.N_REG(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .ra(ra), .rb(rb), .rw(rw), .ld(ld), .ld_data(ld_data),
        .A(A), .B(B), .ALU_OP(ALU_OP), .F(F), .ZF(ZF), .OF(OF),
        .result(result), .flags(flags), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: 000 AND, 001 OR, 010 XOR, 011 NOR,
    // 100 ADD, 101 SUB, 110 SLTU, 111 SHL by b[4:0]
    function automatic logic [31:0] alu_f(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return a + b;
            3'b101:  return a - b;
            3'b110:  return {31'd0, (a < b)};
            default: return a << b[4:0];
        endcase
    endfunction

    function automatic logic alu_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        f = alu_f(o, a, b);
        if (o == 3'b100) return (a[31] == b[31]) && (f[31] != a[31]);
        if (o == 3'b101) return (a[31] != b[31]) && (f[31] != a[31]);
        return 1'b0;
    endfunction

    // External combinational ALU driven by the DUT's registered operands
    always_comb begin
        F  = alu_f(ALU_OP, A, B);
        OF = alu_of(ALU_OP, A, B);
        ZF = (F == 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        chk(tag, rd_data, exp);
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic do_ld(input logic [4:0] addr, input logic [31:0] data);
        ld = 1'b1; rw = addr; ld_data = data;
        @(negedge clk);
        ld = 1'b0;
        if (addr != 5'd0) mreg[addr] = data;
    endtask

    // One full operation. With disturb set, start and ld are pulsed while the
    // block is in READ and EXEC; they must have no effect.
    task automatic run_op(input logic [2:0] o, input logic [4:0] a_, input logic [4:0] b_,
                          input logic [4:0] w_, input bit disturb);
        exp_t        e;
        exp_t        got;
        logic [31:0] av, bv;
        int          extra;
        av    = mreg[a_];
        bv    = mreg[b_];
        e.res = alu_f(o, av, bv);
        e.flg = {(e.res == 32'd0), alu_of(o, av, bv)};
        e.rw  = w_;
        sb.push_back(e);

        start = 1'b1; op = o; ra = a_; rb = b_; rw = w_;
        @(negedge clk);                         // READ
        chk("busy_read", {31'd0, busy}, 32'd1);
        if (disturb) begin
            start = 1'b1; ld = 1'b1; ld_data = 32'hBAD0_BAD0;
            op = 3'b011; ra = 5'd2; rb = 5'd2; rw = 5'd5;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);                         // EXEC
        chk("A_exec", A, av);
        chk("B_exec", B, bv);
        chk("ALU_OP_exec", {29'd0, ALU_OP}, {29'd0, o});
        @(negedge clk);                         // WB
        start = 1'b0; ld = 1'b0;
        chk("result_wb", result, e.res);
        chk("done_wb", {31'd0, done}, 32'd0);
        @(negedge clk);                         // DONE
        chk("done_pulse", {31'd0, done}, 32'd1);
        if (done) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                got = sb.pop_front();
                chk("sb_result", result, got.res);
                chk("sb_flags", {30'd0, flags}, {30'd0, got.flg});
                if (got.rw != 5'd0) mreg[got.rw] = got.res;
                rd_chk("sb_rf_write", got.rw, mreg[got.rw]);
            end
        end
        @(negedge clk);                         // back in IDLE
        chk("done_low", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("busy_extra_done", extra, 0);
            rd_chk("busy_r5_untouched", 5'd5, mreg[5]);
            chk("busy_A_hold", A, av);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rw = '0;
        ld = 1'b0; ld_data = '0; rd_addr = '0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD and result hold
        do_ld(5'd1, 32'h3);
        do_ld(5'd2, 32'h607);
        rd_chk("ld_r1", 5'd1, 32'h3);
        rd_chk("ld_r2", 5'd2, 32'h607);
        run_op(3'b100, 5'd1, 5'd2, 5'd3, 1'b0);
        rd_chk("add_r3", 5'd3, 32'h60A);
        chk("add_result", result, 32'h60A);
        repeat (3) @(negedge clk);
        chk("hold_A", A, 32'h3);
        chk("hold_B", B, 32'h607);
        chk("hold_result", result, 32'h60A);

        // Direct load to R0 is discarded
        do_ld(5'd0, 32'hDEAD_BEEF);
        rd_chk("r0_after_ld", 5'd0, 32'd0);

        // Signed overflow
        do_ld(5'd1, 32'h7FFF_FFFF);
        do_ld(5'd2, 32'h7FFF_FFFF);
        run_op(3'b100, 5'd1, 5'd2, 5'd4, 1'b0);
        chk("ovf_result", result, 32'hFFFF_FFFE);
        chk("ovf_flags", {30'd0, flags}, 32'd1);

        // Zero result written to R0
        run_op(3'b101, 5'd1, 5'd1, 5'd0, 1'b0);
        chk("zero_result", result, 32'd0);
        chk("zero_flags", {30'd0, flags}, 32'd2);
        rd_chk("zero_r0", 5'd0, 32'd0);

        // start/ld while busy are ignored
        run_op(3'b010, 5'd3, 5'd4, 5'd6, 1'b1);

        // Assorted operations on random data
        for (int i = 0; i < 8; i++) begin
            do_ld(5'd7, $urandom);
            do_ld(5'd8, (i == 7) ? 32'd5 : $urandom);
            run_op(i[2:0], 5'd7, 5'd8, 5'(10 + i), 1'b0);
        end
        rd_chk("rand_r10", 5'd10, mreg[10]);

        // Reset in the middle of EXEC
        start = 1'b1; op = 3'b100; ra = 5'd3; rb = 5'd4; rw = 5'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_A", A, 32'd0);
        chk("mid_rst_B", B, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        sb.delete();
        rd_chk("mid_rst_r1", 5'd1, 32'd0);
        rd_chk("mid_rst_r3", 5'd3, 32'd0);
        rd_chk("mid_rst_r4", 5'd4, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First start right after reset release is accepted immediately
        do_ld(5'd1, 32'd9);
        run_op(3'b101, 5'd1, 5'd0, 5'd2, 1'b0);
        rd_chk("post_rst_r2", 5'd2, 32'd9);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
